fpu_cvt_ctrl: RTL and testbench

Issue controller for the shared float/integer conversion unit in the FPU. It arbitrates between two requesters, such as the integer pipe and the FP pipe, using round-robin. It then drives the external conversion datapath with a latched opcode and operand, and waits a fixed number of cycles for the datapath to settle. Finally, it holds the captured result and exception flags on a single valid/ready response channel, tagged with the requester ID.

---
 rtl/fpu_cvt_ctrl.sv | 99 +++++++++
 tb/tb_fpu_cvt_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_ctrl.sv
// Issue controller for the shared float/int conversion datapath: round-robin
// between two requesters, wait LATENCY cycles, then hold the tagged result.
module fpu_cvt_ctrl #(
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [1:0]  req_valid_i,
  input  logic [1:0]  req_op0_i,
  input  logic [1:0]  req_op1_i,
  input  logic [31:0] req_src0_i,
  input  logic [31:0] req_src1_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  cvt_op_o,
  output logic [31:0] cvt_src_o,
  input  logic [31:0] cvt_res_i,
  input  logic [4:0]  cvt_flags_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_flags_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q;
  logic [1:0]  op_q;
  logic [31:0] src_q;
  logic        id_q;
  logic [31:0] data_q;
  logic [4:0]  flags_q;
  logic        win;
  logic        accept;
  logic        capture;

  // Requester 1 wins if it is the only one asking, or on a tie when 0 went last.
  assign win     = req_valid_i[1] & (~req_valid_i[0] | ~last_q);
  assign accept  = (state_q == IDLE) & ~flush_i & (|req_valid_i);
  assign capture = (state_q == EXEC) & (cnt_q == 4'd0) & ~flush_i;

  assign req_ready_o = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign cvt_op_o    = op_q;
  assign cvt_src_o   = src_q;
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_flags_o = flags_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = EXEC;
        cnt_d   = CNT_INIT;
      end
      EXEC: if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
      DONE: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      op_q    <= 2'd0;
      src_q   <= 32'd0;
      id_q    <= 1'b0;
      data_q  <= 32'd0;
      flags_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_q <= win;
        id_q   <= win;
        op_q   <= win ? req_op1_i  : req_op0_i;
        src_q  <= win ? req_src1_i : req_src0_i;
      end
      if (capture) begin
        data_q  <= cvt_res_i;
        flags_q <= cvt_flags_i;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cvt_ctrl.sv
// Bench for fpu_cvt_ctrl: vector table of single ops plus directed sequences for
// arbitration, backpressure, flush and reset; responses checked via a queue.
module tb_fpu_cvt_ctrl;
  localparam int LAT = 4;
  localparam logic [4:0] SETTLE = 5'(LAT - 1);

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [1:0]  req_valid = 2'b00, op0 = 2'd0, op1 = 2'd0;
  logic [31:0] src0 = 32'd0, src1 = 32'd0;
  logic [1:0]  req_ready, cvt_op;
  logic [31:0] cvt_src, cvt_res, rsp_data;
  logic [4:0]  cvt_flags, rsp_flags;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, busy;

  fpu_cvt_ctrl #(.LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid),
    .req_op0_i(op0), .req_op1_i(op1), .req_src0_i(src0), .req_src1_i(src1),
    .req_ready_o(req_ready), .cvt_op_o(cvt_op), .cvt_src_o(cvt_src),
    .cvt_res_i(cvt_res), .cvt_flags_i(cvt_flags), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_flags_o(rsp_flags), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [4:0]  flags;
  } rsp_t;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] src;
    logic [1:0]  ready;
    logic [31:0] data;
    logic [4:0]  flags;
  } vec_t;

  rsp_t exp_q[$];
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference conversion: 3.0 -> 3, NaN -> all-ones with NV, otherwise a
  // scrambled value tagged NX so opcode/operand routing is visible.
  function automatic logic [36:0] model(input logic [1:0] op, input logic [31:0] src);
    if (src == 32'h40400000) return {5'b00000, 32'd3};
    if (src[30:23] == 8'hFF && src[22:0] != 23'd0) return {5'b10000, 32'hFFFFFFFF};
    return {5'b00001, ~src ^ {30'd0, op}};
  endfunction

  // Datapath settles LAT cycles after its inputs change; garbage before that.
  logic [4:0]  age = 5'd31;
  logic [36:0] mres;
  always @(posedge clk)
    if (|(req_ready & req_valid)) age <= 5'd0;
    else if (age != 5'd31)        age <= age + 5'd1;
  assign mres      = model(cvt_op, cvt_src);
  assign cvt_res   = (age >= SETTLE) ? mres[31:0]  : 32'hBAD0BAD0;
  assign cvt_flags = (age >= SETTLE) ? mres[36:32] : 5'h1F;

  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=%h want no response", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic id, input logic [31:0] data, input logic [4:0] flags);
    rsp_t e;
    e.id = id; e.data = data; e.flags = flags;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic id, input logic [1:0] op, input logic [31:0] src);
    if (id) begin op1 = op; src1 = src; end
    else    begin op0 = op; src0 = src; end
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 40) begin tick; n++; end
    chk(name, 32'(n), 32'(LAT));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data,       32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_cvt_op"},    32'(cvt_op),    32'd0);
    chk({tag, "_cvt_src"},   cvt_src,        32'd0);
  endtask

  task automatic single(input vec_t v);
    drive(v.id, v.op, v.src);
    #1;
    chk("single_ready", 32'(req_ready), 32'(v.ready));
    push(v.id, v.data, v.flags);
    tick;
    req_valid = 2'b00;
    chk("single_cvt_src", cvt_src, v.src);
    chk("single_cvt_op", 32'(cvt_op), 32'(v.op));
    chk("single_busy", 32'(busy), 32'd1);
    wait_rsp("single_latency");
    tick;
    chk("single_idle", 32'(busy), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{id: 1'b0, op: 2'd0, src: 32'h40400000, ready: 2'b01, data: 32'd3,         flags: 5'b00000};
    vecs[1] = '{id: 1'b1, op: 2'd1, src: 32'h7FC00000, ready: 2'b10, data: 32'hFFFFFFFF, flags: 5'b10000};
    vecs[2] = '{id: 1'b1, op: 2'd2, src: 32'h12345678, ready: 2'b10, data: 32'hEDCBA985, flags: 5'b00001};
    vecs[3] = '{id: 1'b0, op: 2'd3, src: 32'h00000000, ready: 2'b01, data: 32'hFFFFFFFC, flags: 5'b00001};

    tick; tick;
    check_reset("reset");
    rst = 1'b0;
    tick;

    for (int i = 0; i < 4; i++) single(vecs[i]);

    // Fair arbitration with both requesters always asking.
    rst = 1'b1; tick; rst = 1'b0;
    op0 = 2'd2; src0 = 32'h11111111;
    op1 = 2'd3; src1 = 32'h22222222;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int  n;
      logic [36:0] m;
      n = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && n < 50) begin @(negedge clk); n++; end
      chk("fair_grant", 32'(req_ready), (g % 2) ? 32'd2 : 32'd1);
      if (g > 0) chk("fair_gap", 32'(n), 32'(LAT + 1));
      m = (g % 2) ? model(op1, src1) : model(op0, src0);
      push(1'((g % 2)), m[31:0], m[36:32]);
      @(posedge clk); #1;
      if (g % 2) src1 = src1 + 32'd1;
      else       src0 = src0 + 32'd1;
    end
    req_valid = 2'b00;
    wait_rsp("fair_last_latency");
    tick;
    chk("fair_idle", 32'(busy), 32'd0);

    // Backpressure: response held while the consumer stalls.
    rsp_ready = 1'b0;
    drive(1'b0, 2'd1, 32'h40400000);
    #1;
    chk("bp_ready", 32'(req_ready), 32'd1);
    push(1'b0, 32'd3, 5'd0);
    tick;
    req_valid = 2'b00;
    wait_rsp("bp_latency");
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'd3);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_ready_blocked", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("bp_idle", 32'(busy), 32'd0);

    // Flush two cycles into EXEC kills the operation.
    drive(1'b0, 2'd0, 32'h40400000);
    #1;
    tick;
    req_valid = 2'b00;
    tick; tick;
    flush = 1'b1;
    #1;
    chk("flush_busy_before", 32'(busy), 32'd1);
    tick;
    flush = 1'b0;
    chk("flush_busy_after", 32'(busy), 32'd0);
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
    end
    tick;

    // Flush in IDLE blocks the accept; the request then completes normally.
    flush = 1'b1;
    drive(1'b1, 2'd3, 32'h0000FFFF);
    #1;
    chk("flush_idle_block", 32'(req_ready), 32'd0);
    tick;
    flush = 1'b0;
    req_valid = 2'b00;
    chk("flush_idle_no_accept", 32'(busy), 32'd0);
    single('{id: 1'b1, op: 2'd3, src: 32'h0000FFFF, ready: 2'b10, data: 32'hFFFF0003, flags: 5'b00001});

    // Reset (with flush also high) while a response is pending.
    rsp_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h0F0F0F0F);
    #1;
    tick;
    req_valid = 2'b00;
    wait_rsp("rst_done_latency");
    rst = 1'b1;
    flush = 1'b1;
    tick;
    check_reset("rst_mid");
    rst = 1'b0;
    flush = 1'b0;
    rsp_ready = 1'b1;
    op0 = 2'd0; src0 = 32'h40400000;
    op1 = 2'd1; src1 = 32'h7FC00000;
    req_valid = 2'b11;
    #1;
    chk("rst_tie_grant", 32'(req_ready), 32'd1);
    push(1'b0, 32'd3, 5'd0);
    tick;
    req_valid = 2'b00;
    wait_rsp("rst_tie_latency");
    tick;
    chk("rst_tie_idle", 32'(busy), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
